// File: rtl/return_addr_stack_if.sv
// Return-address-stack bus.
// Groups the push/pop/flush request signals driven by the requester together
// with the popped value, occupancy and status flags returned by the stack.
//   master : drives writeStack, readStack, flush, pc; observes results
//   slave  : the stack itself
interface return_addr_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             writeStack;
  logic             readStack;
  logic             flush;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] stackOut;
  logic             stackValid;
  logic [CNT_W-1:0] count;
  logic             stackEmpty;
  logic             stackFull;
  logic             stackOverflow;
  logic             stackUnderflow;

  modport master (
    output writeStack, readStack, flush, pc,
    input  stackOut, stackValid, count, stackEmpty, stackFull,
           stackOverflow, stackUnderflow
  );

  modport slave (
    input  writeStack, readStack, flush, pc,
    output stackOut, stackValid, count, stackEmpty, stackFull,
           stackOverflow, stackUnderflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Return address stack: circular buffer of DEPTH return addresses with a top
// pointer. Supports push, pop, simultaneous push+pop (replace top / bypass
// when empty), synchronous flush and sticky overflow/underflow flags.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : return_addr_stack_if.slave (requests in, popped value/flags out)
// Parameters:
//   WIDTH    : address width
//   DEPTH    : number of entries (power of two, >= 2)
//   OVF_MODE : 0 = drop push when full, 1 = overwrite oldest entry
module return_addr_stack #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  return_addr_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] top, top_nxt, wr_addr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] out_p1, out_nxt;
  logic             vld_p1, vld_nxt;
  logic             ovf, ovf_nxt;
  logic             unf, unf_nxt;
  logic             wr_en;
  logic             empty, full;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // Request decode: next state of pointer, count, output and flags
  always_comb begin
    top_nxt = top;
    cnt_nxt = cnt;
    out_nxt = out_p1;
    vld_nxt = 1'b0;
    ovf_nxt = ovf;
    unf_nxt = unf;
    wr_en   = 1'b0;
    wr_addr = top + PTR_W'(1);

    if (bus.flush) begin
      top_nxt = '0;
      cnt_nxt = '0;
      out_nxt = '0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else begin
      case ({bus.writeStack, bus.readStack})
        2'b10: begin
          if (!full) begin
            wr_en   = 1'b1;
            top_nxt = top + PTR_W'(1);
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            ovf_nxt = 1'b1;
            // When full, top+1 is the oldest entry, so wrapping overwrites it.
            if (OVF_MODE != 0) begin
              wr_en   = 1'b1;
              top_nxt = top + PTR_W'(1);
            end
          end
        end
        2'b01: begin
          if (!empty) begin
            out_nxt = mem[top];
            vld_nxt = 1'b1;
            top_nxt = top - PTR_W'(1);
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            unf_nxt = 1'b1;
          end
        end
        2'b11: begin
          // Call+return in one cycle: return the current top and replace it,
          // or forward pc straight through when nothing is stacked.
          vld_nxt = 1'b1;
          if (!empty) begin
            out_nxt = mem[top];
            wr_en   = 1'b1;
            wr_addr = top;
          end else begin
            out_nxt = bus.pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      top    <= '0;
      cnt    <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      top    <= top_nxt;
      cnt    <= cnt_nxt;
      out_p1 <= out_nxt;
      vld_p1 <= vld_nxt;
      ovf    <= ovf_nxt;
      unf    <= unf_nxt;
    end
  end

  // Storage (no reset); writes are suppressed while reset is held so an
  // aborted push leaves no trace.
  always_ff @(posedge clock) begin
    if (wr_en && reset)
      mem[wr_addr] <= bus.pc;
  end

  assign bus.stackOut       = out_p1;
  assign bus.stackValid     = vld_p1;
  assign bus.count          = cnt;
  assign bus.stackEmpty     = empty;
  assign bus.stackFull      = full;
  assign bus.stackOverflow  = ovf;
  assign bus.stackUnderflow = unf;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed testbench for return_addr_stack (DEPTH=4, WIDTH=32). Two instances
// share the same stimulus: dut0 drops pushes when full, dut1 overwrites.
module tb_return_addr_stack;

  localparam int W = 32;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        w_req = 1'b0;
  logic        r_req = 1'b0;
  logic        f_req = 1'b0;
  logic [W-1:0] pc_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  return_addr_stack_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  return_addr_stack_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  assign bus0.writeStack = w_req;
  assign bus0.readStack  = r_req;
  assign bus0.flush      = f_req;
  assign bus0.pc         = pc_in;
  assign bus1.writeStack = w_req;
  assign bus1.readStack  = r_req;
  assign bus1.flush      = f_req;
  assign bus1.pc         = pc_in;

  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  // One clock with the given request; outputs are stable 1ns after the edge.
  task automatic cyc(input logic iw, input logic ir, input logic ifl, input logic [W-1:0] ipc);
    w_req = iw; r_req = ir; f_req = ifl; pc_in = ipc;
    @(posedge clock);
    #1;
    w_req = 1'b0; r_req = 1'b0; f_req = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus0.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus0.count); end
    checks++; if (bus0.stackOut !== 32'd0 || bus0.stackValid !== 1'b0) begin errors++; $display("FAIL rst_out got %0d/%0b want 0/0", bus0.stackOut, bus0.stackValid); end
    checks++; if (bus0.stackEmpty !== 1'b1 || bus0.stackFull !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %0b/%0b want 1/0", bus0.stackEmpty, bus0.stackFull); end
    checks++; if (bus0.stackOverflow !== 1'b0 || bus0.stackUnderflow !== 1'b0) begin errors++; $display("FAIL rst_flags got %0b/%0b want 0/0", bus0.stackOverflow, bus0.stackUnderflow); end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_lifo();
    cyc(1, 0, 0, 100);
    cyc(1, 0, 0, 104);
    cyc(1, 0, 0, 108);
    checks++; if (bus0.count !== 3'd3) begin errors++; $display("FAIL lifo_count3 got %0d want 3", bus0.count); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd108 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd2) begin errors++; $display("FAIL lifo_pop1 got %0d/%0b/%0d want 108/1/2", bus0.stackOut, bus0.stackValid, bus0.count); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd104 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd1) begin errors++; $display("FAIL lifo_pop2 got %0d/%0b/%0d want 104/1/1", bus0.stackOut, bus0.stackValid, bus0.count); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd100 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd0) begin errors++; $display("FAIL lifo_pop3 got %0d/%0b/%0d want 100/1/0", bus0.stackOut, bus0.stackValid, bus0.count); end
    checks++; if (bus0.stackEmpty !== 1'b1) begin errors++; $display("FAIL lifo_empty got %0b want 1", bus0.stackEmpty); end
    cyc(0, 0, 0, 0);
    checks++; if (bus0.stackOut !== 32'd100 || bus0.stackValid !== 1'b0) begin errors++; $display("FAIL lifo_hold got %0d/%0b want 100/0", bus0.stackOut, bus0.stackValid); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp0 [4];
    logic [W-1:0] exp1 [4];
    exp0[0] = 4; exp0[1] = 3; exp0[2] = 2; exp0[3] = 1;
    exp1[0] = 5; exp1[1] = 4; exp1[2] = 3; exp1[3] = 2;
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, W'(i));
    checks++; if (bus0.stackOverflow !== 1'b0 || bus0.stackFull !== 1'b1) begin errors++; $display("FAIL ovf_at_full got %0b/%0b want 0/1", bus0.stackOverflow, bus0.stackFull); end
    cyc(1, 0, 0, 5);
    checks++; if (bus0.count !== 3'd4 || bus0.stackFull !== 1'b1 || bus0.stackOverflow !== 1'b1) begin errors++; $display("FAIL ovf0_state got %0d/%0b/%0b want 4/1/1", bus0.count, bus0.stackFull, bus0.stackOverflow); end
    checks++; if (bus1.count !== 3'd4 || bus1.stackOverflow !== 1'b1) begin errors++; $display("FAIL ovf1_state got %0d/%0b want 4/1", bus1.count, bus1.stackOverflow); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      checks++; if (bus0.stackOut !== exp0[i] || bus0.stackValid !== 1'b1) begin errors++; $display("FAIL ovf0_pop%0d got %0d/%0b want %0d/1", i, bus0.stackOut, bus0.stackValid, exp0[i]); end
      checks++; if (bus1.stackOut !== exp1[i] || bus1.stackValid !== 1'b1) begin errors++; $display("FAIL ovf1_pop%0d got %0d/%0b want %0d/1", i, bus1.stackOut, bus1.stackValid, exp1[i]); end
    end
    checks++; if (bus0.count !== 3'd0 || bus0.stackOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d/%0b want 0/1", bus0.count, bus0.stackOverflow); end
  endtask

  task automatic test_underflow();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 55);
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd55) begin errors++; $display("FAIL unf_pre got %0d want 55", bus0.stackOut); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackValid !== 1'b0 || bus0.stackOut !== 32'd55 || bus0.stackUnderflow !== 1'b1 || bus0.count !== 3'd0) begin errors++; $display("FAIL unf_pop got %0b/%0d/%0b/%0d want 0/55/1/0", bus0.stackValid, bus0.stackOut, bus0.stackUnderflow, bus0.count); end
    cyc(1, 0, 0, 66);
    cyc(0, 0, 0, 0);
    checks++; if (bus0.stackUnderflow !== 1'b1 || bus0.count !== 3'd1) begin errors++; $display("FAIL unf_sticky got %0b/%0d want 1/1", bus0.stackUnderflow, bus0.count); end
    // Flush wins over a simultaneous push.
    cyc(1, 0, 1, 77);
    checks++; if (bus0.stackUnderflow !== 1'b0 || bus0.stackOverflow !== 1'b0 || bus0.count !== 3'd0 || bus0.stackOut !== 32'd0) begin errors++; $display("FAIL unf_flush got %0b/%0b/%0d/%0d want 0/0/0/0", bus0.stackUnderflow, bus0.stackOverflow, bus0.count, bus0.stackOut); end
  endtask

  task automatic test_push_pop();
    cyc(1, 0, 0, 10);
    cyc(1, 1, 0, 20);
    checks++; if (bus0.stackOut !== 32'd10 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd1) begin errors++; $display("FAIL pp_replace got %0d/%0b/%0d want 10/1/1", bus0.stackOut, bus0.stackValid, bus0.count); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd20 || bus0.count !== 3'd0) begin errors++; $display("FAIL pp_next got %0d/%0d want 20/0", bus0.stackOut, bus0.count); end
    cyc(1, 1, 0, 7);
    checks++; if (bus0.stackOut !== 32'd7 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd0 || bus0.stackUnderflow !== 1'b0) begin errors++; $display("FAIL pp_bypass got %0d/%0b/%0d/%0b want 7/1/0/0", bus0.stackOut, bus0.stackValid, bus0.count, bus0.stackUnderflow); end
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, W'(i * 11));
    cyc(1, 1, 0, 9);
    checks++; if (bus0.stackOut !== 32'd44 || bus0.count !== 3'd4 || bus0.stackOverflow !== 1'b0) begin errors++; $display("FAIL pp_full got %0d/%0d/%0b want 44/4/0", bus0.stackOut, bus0.count, bus0.stackOverflow); end
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd9 || bus0.count !== 3'd3) begin errors++; $display("FAIL pp_full_pop got %0d/%0d want 9/3", bus0.stackOut, bus0.count); end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, W'(i));
    cyc(0, 1, 0, 0);
    checks++; if (bus0.count !== 3'd3 || bus0.stackOut !== 32'd4) begin errors++; $display("FAIL ar_pre got %0d/%0d want 3/4", bus0.count, bus0.stackOut); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus0.count !== 3'd0 || bus0.stackOut !== 32'd0 || bus0.stackEmpty !== 1'b1) begin errors++; $display("FAIL ar_async got %0d/%0d/%0b want 0/0/1", bus0.count, bus0.stackOut, bus0.stackEmpty); end
    // A push held across an edge during reset is ignored.
    cyc(1, 0, 0, 33);
    checks++; if (bus0.count !== 3'd0) begin errors++; $display("FAIL ar_hold got %0d want 0", bus0.count); end
    #2;
    reset = 1'b1;
    cyc(1, 0, 0, 9);
    cyc(0, 1, 0, 0);
    checks++; if (bus0.stackOut !== 32'd9 || bus0.stackValid !== 1'b1 || bus0.count !== 3'd0) begin errors++; $display("FAIL ar_after got %0d/%0b/%0d want 9/1/0", bus0.stackOut, bus0.stackValid, bus0.count); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
